// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter that feeds one shared, enable-gated register.
// Supports locked bursts capped at MAX_BURST consecutive grants per owner.
module reg_write_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*WIDTH-1:0]   data_in,
  output logic [NREQ-1:0]         grant,
  output logic                    enable,
  output logic [WIDTH-1:0]        wr_data,
  output logic                    locked,
  output logic [WIDTH-1:0]        q
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;

  state_t           state, next_state;
  logic [PTR_W-1:0] ptr, next_ptr;
  logic [PTR_W-1:0] owner, next_owner;
  logic [CNT_W-1:0] burst_cnt, next_cnt;
  logic [NREQ-1:0]  next_grant;
  logic [WIDTH-1:0] next_wr_data;

  logic             found;
  logic [PTR_W-1:0] win;
  int               scan_idx;
  logic             cont_lock;

  // First requesting index at or above ptr, wrapping around.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found    = 1'b0;
    win      = '0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (int'(ptr) + k) % NREQ;
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = PTR_W'(scan_idx);
      end
    end
  end

  assign cont_lock = (state == LOCK) && req[owner] && lock[owner] &&
                     (burst_cnt < CNT_LAST);

  always_comb begin
    next_state   = IDLE;
    next_grant   = '0;
    next_wr_data = wr_data;
    next_ptr     = ptr;
    next_owner   = owner;
    next_cnt     = '0;
    if (cont_lock) begin
      next_state        = LOCK;
      next_grant[owner] = 1'b1;
      next_wr_data      = data_in[owner*WIDTH +: WIDTH];
      next_cnt          = burst_cnt + 1'b1;
    end else if (found) begin
      next_state      = lock[win] ? LOCK : GRANT;
      next_grant[win] = 1'b1;
      next_wr_data    = data_in[win*WIDTH +: WIDTH];
      next_ptr        = (win == PTR_MAX) ? '0 : win + 1'b1;
      next_owner      = win;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      grant     <= '0;
      wr_data   <= '0;
      q         <= '0;
    end else begin
      state     <= next_state;
      ptr       <= next_ptr;
      owner     <= next_owner;
      burst_cnt <= next_cnt;
      grant     <= next_grant;
      wr_data   <= next_wr_data;
      if (enable) q <= wr_data;
    end
  end

  // Both derive from registers only, so no input reaches an output combinationally.
  assign enable = |grant;
  assign locked = (state == LOCK);

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin write arbiter that shares one enable-gated storage register (data/enable/q resource) among NREQ requesters.
- Each cycle it picks at most one requester and drives that requester's data and a one-cycle write enable into the register.
- Supports locked bursts, with a bounded hold so no requester starves.
- Sits between requester logic and the shared register; the register is instantiated inside this block and its output is exposed on q.

Parameters:
- WIDTH, 8, data and register width in bits.
- NREQ, 4, number of requesters; legal range 2..8.
- MAX_BURST, 4, maximum consecutive grants to one locked owner; legal range 1..16.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester write request, level-sensitive.
- lock  input  NREQ  per-requester burst lock; only meaningful together with req.
- data_in  input  NREQ*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- grant  output  NREQ  registered one-hot grant, or all zero; doubles as the per-requester ack.
- enable  output  1  registered write enable to the register; equals |grant.
- wr_data  output  WIDTH  registered data presented to the register.
- locked  output  1  high while the FSM is in LOCK.
- q  output  WIDTH  register contents.

Behaviour:
- Reset (sampled at the edge) clears the following: grant=0, enable=0, wr_data=0, q=0, locked=0, ptr=0, burst_cnt=0, state=IDLE.
- Reset overrides everything, including an in-flight write or a LOCK.
- Internal state:
  - ptr, log2(NREQ) bits: index of the highest-priority requester.
  - owner: index of the last granted requester.
  - burst_cnt: counts grants within a locked burst.
- FSM states:
  - IDLE: no grant.
  - GRANT: single grant this cycle.
  - LOCK: owner holds the resource.
- Per edge, when not in reset, exactly one of the following applies:
  1. Continue lock: state==LOCK, req[owner]&lock[owner]==1 and burst_cnt < MAX_BURST-1.
     - grant=onehot(owner), wr_data=data_in[owner], burst_cnt+1.
     - Stay in LOCK; ptr unchanged.
  2. Arbitrate: otherwise, if any req is set.
     - Winner w is the first set bit scanning from ptr upward with wrap.
     - grant=onehot(w), wr_data=data_in[w], ptr=(w+1) mod NREQ, owner=w, burst_cnt=0.
     - Next state is LOCK if lock[w] is set, otherwise GRANT.
     - A requester whose burst expired is therefore re-eligible, but only after every other requester; if it is the sole requester it wins again and starts a new burst.
  3. Idle: otherwise.
     - grant=0, state=IDLE, burst_cnt=0.
     - wr_data holds its last value.
- enable equals |grant (registered). locked equals (state==LOCK).
- Register: at each edge, if enable==1 then q<=wr_data.
- Latency:
  - req/data sampled at edge k produce grant, enable and wr_data after edge k.
  - q updates at edge k+1.
  - Total latency is 2 edges from sampling to visible q.
- Handshake:
  - grant[i] high for one cycle means data_in[i] was taken.
  - A requester wanting exactly one write drops req in the cycle grant[i] is seen. A req still high at the next edge counts as a new request.
  - data_in is sampled only at the winning edge and does not need to be held afterwards.
- Lock rules:
  - With MAX_BURST=1, lock has no effect: the FSM enters LOCK but the continue condition is never met.
  - Dropping lock or req ends the burst at the next edge, and normal arbitration applies that same edge.
- Simultaneous requests: at most one grant per cycle; never more than one grant bit set.
- ptr advances only on rule-2 grants. ptr wraps from NREQ-1 to 0.
- An X-free reset is required. No output may depend combinationally on the inputs.

Test Plan (WIDTH=8, NREQ=4, MAX_BURST=4):
- Reset check: assert reset for 2 cycles with random req -> grant=0, enable=0, wr_data=0, q=0, locked=0. Then, with req=0001 and data0=8'hA5: grant=0001 one edge later, q=8'hA5 one further edge later.
- Fairness: req=1111 held for 8 cycles, data_in[i]=8'h10+i -> grant sequence 0001,0010,0100,1000,0001,…; q trails wr_data by one cycle.
- Two-way alternation: req=0101 held -> grant alternates 0001/0100 and is never zero. Then drop req[0] -> grant=0100 every cycle.
- Lock burst: req=0011, lock=0001 from reset.
  - grant=0001 for 4 consecutive cycles with locked=1 and burst_cnt 0..3.
  - Then grant=0010 (forced release) with locked=0, then 0001 again.
- Early unlock: start the lock burst above, drop lock[0] after 2 grants -> the next grant goes to requester 1 and locked falls the same edge.
- Reset mid-operation: assert reset while locked=1 and enable=1 -> at the next edge everything is zero, the pending wr_data is not written, and after release the first grant goes to requester 0 (ptr=0).
